trigger_frame_packer: RTL and testbench

- Sits directly downstream of data_trigger and consumes its triggered output stream: sample data, trigger info, timestamp and trigger config packed into one TDATA word.
- Wraps each contiguous TVALID burst into a framed AXI-Stream packet: header word, data words, footer word, with TLAST on the footer.
- Buffers in an internal FIFO so the downstream DMA/serializer can apply TREADY backpressure. The upstream stream has no TREADY.

---
 rtl/trigger_frame_packer.sv | 191 +++++++++++++++++++
 tb/tb_trigger_frame_packer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_frame_packer.sv
// Frames each contiguous trigger-window burst as header, data words, footer (TLAST) into an output FIFO.
// Latency: header visible one cycle after the first beat's edge; data word k one cycle after beat k.
// Backpressure: M_AXIS_TREADY stalls the FIFO; upstream cannot stall, so frames are truncated or dropped on overflow.
//
// Ports: ACLK/ARESET (sync, active-high); S_AXIS_TDATA/TVALID trigger stream in ({cfg, ts, info, samples});
//        M_AXIS_TDATA/TVALID/TREADY/TLAST framed stream out; DROPPED_FRAME_COUNT saturating drop counter.
module trigger_frame_packer #(
    parameter int SAMPLE_WIDTH         = 16,
    parameter int SAMPLE_NUM_PER_CLK   = 8,
    parameter int TRIGGER_INFO_WIDTH   = 8,
    parameter int TIMESTAMP_WIDTH      = 24,
    parameter int TRIGGER_CONFIG_WIDTH = 16,
    parameter logic [7:0] CHANNEL_ID   = 8'h00,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic [SAMPLE_WIDTH*SAMPLE_NUM_PER_CLK+TRIGGER_INFO_WIDTH+TIMESTAMP_WIDTH+TRIGGER_CONFIG_WIDTH-1:0] S_AXIS_TDATA,
    input  logic S_AXIS_TVALID,
    output logic [SAMPLE_WIDTH*SAMPLE_NUM_PER_CLK-1:0] M_AXIS_TDATA,
    output logic M_AXIS_TVALID,
    input  logic M_AXIS_TREADY,
    output logic M_AXIS_TLAST,
    output logic [15:0] DROPPED_FRAME_COUNT
);
    localparam int DW = SAMPLE_WIDTH * SAMPLE_NUM_PER_CLK;
    localparam int TI = TRIGGER_INFO_WIDTH;
    localparam int TS = TIMESTAMP_WIDTH;
    localparam int TC = TRIGGER_CONFIG_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] FREE_HDR = (AW+1)'(3);  // header + one data + footer
    localparam logic [AW:0] FREE_DAT = (AW+1)'(2);  // data + reserved footer slot

    typedef enum logic [1:0] {IDLE, STREAM, FOOTER, DROP} state_t;
    state_t state, next_state;

    // Input field split
    logic [DW-1:0] samples;
    logic [TI-1:0] info;
    logic [TS-1:0] ts;
    logic [TC-1:0] cfg;
    assign samples = S_AXIS_TDATA[DW-1:0];
    assign info    = S_AXIS_TDATA[DW +: TI];
    assign ts      = S_AXIS_TDATA[DW+TI +: TS];
    assign cfg     = S_AXIS_TDATA[DW+TI+TS +: TC];

    // Frame context
    logic [DW-1:0] hold;
    logic [15:0]   word_cnt;
    logic          truncated;

    // Output FIFO (first-word-fall-through)
    logic [DW:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt, free;
    logic          rd_en;
    logic [DW:0]   rd_word;

    // Control
    logic          wr_en, wr_last, hold_ld, frame_clr, cnt_inc, trunc_set, drop_inc;
    logic [DW-1:0] wr_word, header, footer;

    assign free  = DEPTH - fifo_cnt;  // taken before this cycle's read
    assign rd_en = M_AXIS_TVALID && M_AXIS_TREADY;

    always_comb begin
        header = '0;
        header[DW-1 -: 8]           = 8'hAA;
        header[DW-9 -: 8]           = CHANNEL_ID;
        header[DW-17 -: TS]         = ts;
        header[DW-17-TS -: TC]      = cfg;
        header[DW-17-TS-TC -: TI]   = info;
    end

    always_comb begin
        footer = '0;
        footer[DW-1 -: 8]  = 8'h55;
        footer[DW-9 -: 16] = word_cnt;
        footer[DW-25]      = truncated;
    end

    // FSM: state register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= next_state;
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (S_AXIS_TVALID) next_state = (free >= FREE_HDR) ? STREAM : DROP;
            STREAM:  if (!S_AXIS_TVALID) next_state = FOOTER;
            FOOTER:  next_state = S_AXIS_TVALID ? DROP : IDLE;
            DROP:    if (!S_AXIS_TVALID) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        wr_word   = header;
        hold_ld   = 1'b0;
        frame_clr = 1'b0;
        cnt_inc   = 1'b0;
        trunc_set = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (S_AXIS_TVALID) begin
                    if (free >= FREE_HDR) begin
                        wr_en     = 1'b1;
                        hold_ld   = 1'b1;
                        frame_clr = 1'b1;
                    end else begin
                        drop_inc  = 1'b1;
                    end
                end
            end
            STREAM: begin
                // Once truncated, stay truncated so the frame never has holes.
                if (free >= FREE_DAT && !truncated) begin
                    wr_en   = 1'b1;
                    wr_word = hold;
                    cnt_inc = 1'b1;
                end else begin
                    trunc_set = 1'b1;
                end
                hold_ld = S_AXIS_TVALID;
            end
            FOOTER: begin
                wr_en    = 1'b1;
                wr_word  = footer;
                wr_last  = 1'b1;
                drop_inc = S_AXIS_TVALID;  // burst restarted with a 1-cycle gap
            end
            default: ;
        endcase
    end

    // Frame context and drop counter
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            hold                <= '0;
            word_cnt            <= '0;
            truncated           <= 1'b0;
            DROPPED_FRAME_COUNT <= '0;
        end else begin
            if (hold_ld) hold <= samples;
            if (frame_clr) begin
                word_cnt  <= '0;
                truncated <= 1'b0;
            end else begin
                if (cnt_inc && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
                if (trunc_set) truncated <= 1'b1;
            end
            if (drop_inc && DROPPED_FRAME_COUNT != 16'hFFFF)
                DROPPED_FRAME_COUNT <= DROPPED_FRAME_COUNT + 16'd1;
        end
    end

    // FIFO storage: no reset so it maps onto RAM
    always_ff @(posedge ACLK) begin
        if (wr_en) mem[wr_ptr] <= {wr_last, wr_word};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rd_word       = mem[rd_ptr];
    assign M_AXIS_TVALID = (fifo_cnt != '0);
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? rd_word[DW-1:0] : '0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID ? rd_word[DW] : 1'b0;

endmodule

// File: tb/tb_trigger_frame_packer.sv
// Bench for trigger_frame_packer: randomized bursts against a queue-based frame model.
// Latency: model updates on each rising edge; outputs compared on the falling edge.
// Backpressure: M_AXIS_TREADY driven fixed or random per cycle.
module tb_trigger_frame_packer;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic [175:0] s_dat = '0;
    logic         s_vld = 1'b0;
    logic [127:0] m_dat;
    logic         m_vld;
    logic         m_rdy = 1'b1;
    logic         m_last;
    logic [15:0]  dropped;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 0;

    trigger_frame_packer dut (
        .ACLK(clk), .ARESET(areset),
        .S_AXIS_TDATA(s_dat), .S_AXIS_TVALID(s_vld),
        .M_AXIS_TDATA(m_dat), .M_AXIS_TVALID(m_vld), .M_AXIS_TREADY(m_rdy),
        .M_AXIS_TLAST(m_last), .DROPPED_FRAME_COUNT(dropped)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [128:0] q[$];     // expected output words {last, data} still in the FIFO
    logic [128:0] got[$];   // words actually accepted downstream
    logic [127:0] sent[$];  // sample words driven in the current directed burst
    int           m_ph = 0; // 0 waiting, 1 in frame, 2 closing frame, 3 discarding burst
    logic [127:0] m_hold;
    int           m_cnt;
    bit           m_tr;
    int           m_drop = 0;

    function automatic logic [127:0] mk_hdr(input logic [175:0] b);
        return {8'hAA, 8'h00, b[159:136], b[175:160], b[135:128], 64'h0};
    endfunction

    function automatic logic [127:0] mk_ftr(input int n, input bit tr);
        logic [15:0] c;
        c = (n > 65535) ? 16'hFFFF : 16'(n);
        return {8'h55, c, tr, 103'h0};
    endfunction

    always @(posedge clk) begin : model
        int free;
        if (areset) begin
            q.delete();
            m_ph   = 0;
            m_drop = 0;
        end else begin
            free = DEPTH - q.size();
            if (m_rdy && q.size() > 0) void'(q.pop_front());
            case (m_ph)
                0: if (s_vld) begin
                    if (free >= 3) begin
                        q.push_back({1'b0, mk_hdr(s_dat)});
                        m_hold = s_dat[127:0];
                        m_cnt  = 0;
                        m_tr   = 0;
                        m_ph   = 1;
                    end else begin
                        if (m_drop < 65535) m_drop++;
                        m_ph = 3;
                    end
                end
                1: begin
                    if (!m_tr && free >= 2) begin
                        q.push_back({1'b0, m_hold});
                        m_cnt++;
                    end else m_tr = 1;
                    if (s_vld) m_hold = s_dat[127:0];
                    else       m_ph = 2;
                end
                2: begin
                    q.push_back({1'b1, mk_ftr(m_cnt, m_tr)});
                    if (s_vld) begin
                        if (m_drop < 65535) m_drop++;
                        m_ph = 3;
                    end else m_ph = 0;
                end
                default: if (!s_vld) m_ph = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if (m_vld !== (q.size() != 0)) begin
            errors++;
            $display("FAIL tvalid t=%0t got %b want %b", $time, m_vld, q.size() != 0);
        end
        if (q.size() != 0) begin
            checks++;
            if ({m_last, m_dat} !== q[0]) begin
                errors++;
                $display("FAIL word t=%0t got %h want %h", $time, {m_last, m_dat}, q[0]);
            end
        end
        checks++;
        if (dropped !== 16'(m_drop)) begin
            errors++;
            $display("FAIL dropped t=%0t got %0d want %0d", $time, dropped, m_drop);
        end
        if (m_vld === 1'b1 && m_rdy) got.push_back({m_last, m_dat});
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) m_rdy = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            s_vld = 1'b0;
        end
    endtask

    task automatic burst(input int n, input int gap, input logic [23:0] ts,
                         input logic [15:0] cfg, input logic [7:0] info);
        logic [127:0] smp;
        for (int i = 0; i < n; i++) begin
            tick();
            smp = {$urandom, $urandom, $urandom, $urandom};
            sent.push_back(smp);
            if (i == 0) s_dat = {cfg, ts, info, smp};
            else        s_dat = {16'($urandom), 24'($urandom), 8'($urandom), smp};
            s_vld = 1'b1;
        end
        idle(gap);
    endtask

    task automatic drain();
        int i;
        rnd_rdy = 0;
        m_rdy   = 1'b1;
        i = 0;
        while (i < 400 && (q.size() != 0 || m_vld !== 1'b0)) begin
            tick();
            s_vld = 1'b0;
            i++;
        end
        checks++;
        if (q.size() != 0 || m_vld !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout got %0d left want 0", q.size());
        end
        idle(2);
    endtask

    task automatic do_reset();
        tick();
        areset = 1'b1;
        s_vld  = 1'b0;
        idle(2);
        areset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        chk("reset_tvalid", 129'(m_vld), 129'(0));
        chk("reset_tlast", 129'(m_last), 129'(0));
        chk("reset_tdata", 129'(m_dat), 129'(0));
        chk("reset_dropped", 129'(dropped), 129'(0));

        // 4-beat frame, free-running downstream
        got.delete(); sent.delete();
        burst(4, 10, 24'h000010, 16'h1234, 8'h01);
        drain();
        chk("t1_len", 129'(got.size()), 129'(6));
        if (got.size() == 6) begin
            chk("t1_hdr", got[0], {1'b0, 8'hAA, 8'h00, 24'h000010, 16'h1234, 8'h01, 64'h0});
            for (int i = 0; i < 4; i++) chk("t1_data", got[i+1], {1'b0, sent[i]});
            chk("t1_ftr", got[5], {1'b1, 8'h55, 16'd4, 1'b0, 103'h0});
        end
        chk("t1_dropped", 129'(dropped), 129'(0));

        // 20 beats into a stalled FIFO: truncated at 14 data words
        got.delete(); sent.delete();
        m_rdy = 1'b0;
        burst(20, 4, 24'hABCDEF, 16'h0F0F, 8'h80);
        chk("t2_level", 129'(q.size()), 129'(16));
        drain();
        chk("t2_len", 129'(got.size()), 129'(16));
        if (got.size() == 16) begin
            for (int i = 0; i < 14; i++) chk("t2_data", got[i+1], {1'b0, sent[i]});
            chk("t2_ftr", got[15], {1'b1, 8'h55, 16'd14, 1'b1, 103'h0});
        end

        // FIFO at 14 entries, next burst dropped
        got.delete(); sent.delete();
        m_rdy = 1'b0;
        burst(12, 2, 24'h1, 16'h2, 8'h3);
        burst(5, 3, 24'h4, 16'h5, 8'h6);
        chk("t3_dropped", 129'(dropped), 129'(1));
        drain();
        chk("t3_len", 129'(got.size()), 129'(14));
        got.delete();
        burst(3, 6, 24'h7, 16'h8, 8'h9);
        drain();
        chk("t3_next_len", 129'(got.size()), 129'(5));
        if (got.size() == 5) chk("t3_next_ftr", got[4], {1'b1, 8'h55, 16'd3, 1'b0, 103'h0});

        // 1-cycle gap drops the second burst; 2-cycle gap keeps both
        do_reset();
        got.delete();
        burst(3, 1, 24'h11, 16'h22, 8'h33);
        burst(3, 8, 24'h44, 16'h55, 8'h66);
        drain();
        chk("t4_gap1_len", 129'(got.size()), 129'(5));
        chk("t4_gap1_dropped", 129'(dropped), 129'(1));
        if (got.size() == 5) chk("t4_gap1_ftr", got[4], {1'b1, 8'h55, 16'd3, 1'b0, 103'h0});
        got.delete();
        burst(3, 2, 24'h11, 16'h22, 8'h33);
        burst(3, 8, 24'h44, 16'h55, 8'h66);
        drain();
        chk("t4_gap2_len", 129'(got.size()), 129'(10));
        chk("t4_gap2_dropped", 129'(dropped), 129'(1));

        // Random backpressure, random burst lengths
        rnd_rdy = 1;
        for (int b = 0; b < 10; b++)
            burst($urandom_range(5, 50), $urandom_range(2, 6),
                  24'($urandom), 16'($urandom), 8'($urandom));
        drain();

        // Reset in the middle of a burst
        got.delete(); sent.delete();
        burst(3, 0, 24'h99, 16'h88, 8'h77);
        tick();
        areset = 1'b1;
        s_vld  = 1'b1;
        tick();
        areset = 1'b0;
        s_vld  = 1'b0;
        chk("t6_tvalid", 129'(m_vld), 129'(0));
        chk("t6_dropped", 129'(dropped), 129'(0));
        idle(3);
        got.delete();
        burst(4, 8, 24'h000123, 16'hBEEF, 8'h02);
        drain();
        chk("t6_len", 129'(got.size()), 129'(6));
        if (got.size() == 6) begin
            chk("t6_hdr", got[0], {1'b0, 8'hAA, 8'h00, 24'h000123, 16'hBEEF, 8'h02, 64'h0});
            chk("t6_ftr", got[5], {1'b1, 8'h55, 16'd4, 1'b0, 103'h0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
